// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte image
// into 32-bit words, writes them to inst_mem and releases the CPU once the checksum matches.
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [CNT_WIDTH-1:0] word_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    function automatic logic [7:0] checksum_update(input logic [7:0] sum, input logic [7:0] b);
        return sum ^ b;
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [1:0]             byte_idx_r;
    logic [31:0]            len_r;
    logic [23:0]            asm_r;
    logic [7:0]             checksum_r;
    logic                   rx_ready_r;
    logic                   mem_we_r;
    logic [31:0]            mem_addr_r;
    logic [31:0]            mem_wdata_r;
    logic                   cpu_reset_r;
    logic                   load_done_r;
    logic                   load_error_r;
    logic [CNT_WIDTH-1:0]   word_count_r;

    logic                   accept_s;
    logic                   word_end_s;
    logic                   last_word_s;
    logic [31:0]            len_full_s;
    logic [31:0]            next_addr_s;

    assign accept_s    = rx_valid && rx_ready_r;
    assign word_end_s  = accept_s && (byte_idx_r == 2'd3);
    // Length arrives LSB first, so the 4th byte completes the top of the shift register.
    assign len_full_s  = {rx_data, len_r[31:8]};
    assign last_word_s = (({{(32-CNT_WIDTH){1'b0}}, word_count_r} + 32'd1) == len_r);
    assign next_addr_s = BASE_ADDR + {{(30-CNT_WIDTH){1'b0}}, word_count_r, 2'b00};

    // Next-state decode for the load sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_LEN;
            end
            ST_LEN: begin
                if (word_end_s) begin
                    if ((len_full_s == 32'd0) || (len_full_s > MAX_LEN)) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (word_end_s && last_word_s) begin
                    state_s = ST_CHK;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (rx_data == checksum_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else begin
                    state_s = ST_CHK;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Byte counter, length capture, word assembler and data checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx_r <= 2'd0;
            len_r      <= 32'd0;
            asm_r      <= 24'd0;
            checksum_r <= 8'd0;
        end else begin
            if (accept_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
            end else begin
                byte_idx_r <= byte_idx_r;
            end
            if (accept_s && (state_r == ST_LEN)) begin
                len_r <= len_full_s;
            end else begin
                len_r <= len_r;
            end
            if (accept_s && (state_r == ST_DATA)) begin
                asm_r      <= {rx_data, asm_r[23:8]};
                checksum_r <= checksum_update(checksum_r, rx_data);
            end else begin
                asm_r      <= asm_r;
                checksum_r <= checksum_r;
            end
        end
    end

    // Write port: one pulse the cycle after a word's 4th byte; address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_r     <= 1'b0;
            mem_addr_r   <= BASE_ADDR;
            mem_wdata_r  <= 32'd0;
            word_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (word_end_s && (state_r == ST_DATA)) begin
                mem_we_r     <= 1'b1;
                mem_addr_r   <= next_addr_s;
                mem_wdata_r  <= {rx_data, asm_r};
                word_count_r <= word_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                mem_we_r     <= 1'b0;
                mem_addr_r   <= mem_addr_r;
                mem_wdata_r  <= mem_wdata_r;
                word_count_r <= word_count_r;
            end
        end
    end

    // Registered decodes of the upcoming state for handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ready_r   <= 1'b0;
            cpu_reset_r  <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            rx_ready_r   <= (state_s == ST_LEN) || (state_s == ST_DATA) || (state_s == ST_CHK);
            cpu_reset_r  <= (state_s != ST_DONE);
            load_done_r  <= (state_s == ST_DONE);
            load_error_r <= (state_s == ST_ERR);
        end
    end

    assign rx_ready   = rx_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_reset  = cpu_reset_r;
    assign load_done  = load_done_r;
    assign load_error = load_error_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed and random images checked
// against a byte-stream reference model of the load protocol.
module tb_inst_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [8:0]  word_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int overlap = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          acc_cyc_q[$];
    logic [7:0]  acc_byte_q[$];

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_trig_q[$];
    int          exp_acc;
    bit          exp_done;

    bq_t good_s;

    inst_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_WIDTH(9)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            acc_cyc_q.push_back(cyc);
            acc_byte_q.push_back(rx_data);
        end
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (load_done && load_error) overlap++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: what the loader should write and how the load should end.
    task automatic model(input bq_t s);
        logic [31:0] len;
        logic [7:0]  sum;
        int          n;
        exp_addr_q.delete(); exp_data_q.delete(); exp_trig_q.delete();
        len = {s[3], s[2], s[1], s[0]};
        if (len == 32'd0 || len > MAXW) begin
            exp_acc  = 4;
            exp_done = 1'b0;
        end else begin
            n   = int'(len);
            sum = 8'd0;
            for (int w = 0; w < n; w++) begin
                exp_data_q.push_back({s[4*w+7], s[4*w+6], s[4*w+5], s[4*w+4]});
                exp_addr_q.push_back(BASE + 32'(4*w));
                exp_trig_q.push_back(4*w + 7);
                sum = sum ^ s[4*w+4] ^ s[4*w+5] ^ s[4*w+6] ^ s[4*w+7];
            end
            exp_acc  = 4 + 4*n + 1;
            exp_done = (s[4+4*n] == sum);
        end
    endtask

    task automatic make_stream(input int nwords, input bit good_sum, output bq_t s);
        logic [7:0]  sum;
        logic [31:0] len;
        logic [7:0]  b;
        s.delete();
        len = 32'(nwords);
        for (int i = 0; i < 4; i++) s.push_back(len[8*i +: 8]);
        sum = 8'd0;
        for (int i = 0; i < 4*nwords; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            sum = sum ^ b;
        end
        if (good_sum) s.push_back(sum);
        else          s.push_back(sum ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        acc_cyc_q.delete(); acc_byte_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        int w;
        repeat (gap) begin
            rx_valid = 1'b0; rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1; rx_data = b;
        got = 1'b0; w = 0;
        while (!got && w < 50) begin
            @(negedge clk);
            got = rx_ready;
            @(posedge clk); #1;
            w++;
        end
        rx_valid = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout: byte %02h not accepted, required acceptance within 50 cycles", b);
        end
    endtask

    // Scenario: stream an image, then compare writes, latency and final status to the model.
    task automatic run_stream(input string name, input bq_t s, input int gap);
        int nw;
        model(s);
        for (int i = 0; i < exp_acc; i++) send_byte(s[i], gap);
        for (int w = 0; w < 10 && !(load_done || load_error); w++) @(posedge clk);
        @(negedge clk);
        total++;
        if (wr_addr_q.size() !== exp_addr_q.size()) begin
            bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), exp_addr_q.size());
        end
        nw = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < nw; i++) begin
            total++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                bad++;
                $display("FAIL %s write[%0d]: got addr %h data %h required addr %h data %h",
                         name, i, wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
            end
            if (exp_trig_q[i] < acc_cyc_q.size()) begin
                total++;
                if (wr_cyc_q[i] !== acc_cyc_q[exp_trig_q[i]] + 1) begin
                    bad++;
                    $display("FAIL %s we_latency[%0d]: got cycle %0d required %0d",
                             name, i, wr_cyc_q[i], acc_cyc_q[exp_trig_q[i]] + 1);
                end
            end
        end
        total++;
        if (acc_byte_q.size() !== exp_acc) begin
            bad++;
            $display("FAIL %s accepted_bytes: got %0d required %0d", name, acc_byte_q.size(), exp_acc);
        end
        for (int i = 0; i < acc_byte_q.size() && i < exp_acc; i++) begin
            total++;
            if (acc_byte_q[i] !== s[i]) begin
                bad++;
                $display("FAIL %s accepted_byte[%0d]: got %02h required %02h", name, i, acc_byte_q[i], s[i]);
            end
        end
        total++;
        if ({load_done, load_error, cpu_reset} !== {exp_done, !exp_done, !exp_done}) begin
            bad++;
            $display("FAIL %s status(done,err,cpu_rst): got %b%b%b required %b%b%b", name,
                     load_done, load_error, cpu_reset, exp_done, !exp_done, !exp_done);
        end
        total++;
        if (word_count !== 9'(exp_addr_q.size())) begin
            bad++;
            $display("FAIL %s word_count: got %0d required %0d", name, word_count, exp_addr_q.size());
        end
        total++;
        if (overlap !== 0) begin
            bad++;
            $display("FAIL %s done_err_overlap: got %0d cycles required 0", name, overlap);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({rx_ready, mem_we, cpu_reset, load_done, load_error} !== 5'b00100 && !(rx_ready === 1'b1)) begin
            bad++;
            $display("FAIL reset_flags: got %b required 00100 (rx_ready may rise after IDLE)",
                     {rx_ready, mem_we, cpu_reset, load_done, load_error});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rx_ready, mem_we, cpu_reset, load_done, load_error} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_flags_held: got %b required 00100", {rx_ready, mem_we, cpu_reset, load_done, load_error});
        end
        total++;
        if (mem_addr !== BASE || mem_wdata !== 32'd0 || word_count !== 9'd0) begin
            bad++;
            $display("FAIL reset_regs: got addr %h data %h wc %0d required %h 0 0", mem_addr, mem_wdata, word_count, BASE);
        end
        do_reset();
    endtask

    task automatic test_good_load();
        do_reset();
        run_stream("good", good_s, 0);
        total++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h0000_0013 || wr_data_q[1] !== 32'h0010_0093
            || wr_addr_q[1] !== 32'h0000_0004) begin
            bad++;
            $display("FAIL good_words: got %0d writes required 0x0:00000013 0x4:00100093", wr_data_q.size());
        end
    endtask

    task automatic test_post_done();
        clear_mon();
        rx_valid = 1'b1; rx_data = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        total++;
        if (acc_byte_q.size() !== 0 || wr_addr_q.size() !== 0 || rx_ready !== 1'b0 || load_done !== 1'b1) begin
            bad++;
            $display("FAIL post_done: got accepts %0d writes %0d rx_ready %b done %b required 0 0 0 1",
                     acc_byte_q.size(), wr_addr_q.size(), rx_ready, load_done);
        end
    endtask

    task automatic test_bad_checksum();
        bq_t s;
        s = good_s;
        s[12] = 8'h91;
        do_reset();
        run_stream("bad_chk", s, 0);
    endtask

    task automatic test_len_bounds();
        bq_t s;
        logic [31:0] big;
        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        run_stream("len0", s, 0);
        s = '{8'h01, 8'h01, 8'h00, 8'h00};
        do_reset();
        run_stream("len257", s, 0);
        big = 32'($urandom_range(257, 32'h7FFF_FFFF));
        s = '{big[7:0], big[15:8], big[23:16], big[31:24]};
        do_reset();
        run_stream("len_big", s, 1);
        make_stream(MAXW, 1'b1, s);
        do_reset();
        run_stream("len256", s, 0);
    endtask

    task automatic test_gaps();
        do_reset();
        run_stream("gaps", good_s, 3);
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(good_s[i], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rx_ready, mem_we, cpu_reset, load_done, load_error} !== 5'b00100
            || mem_addr !== BASE || mem_wdata !== 32'd0 || word_count !== 9'd0) begin
            bad++;
            $display("FAIL mid_reset: got flags %b addr %h data %h wc %0d required 00100 %h 0 0",
                     {rx_ready, mem_we, cpu_reset, load_done, load_error}, mem_addr, mem_wdata, word_count, BASE);
        end
        reset = 1'b0;
        clear_mon();
        run_stream("after_reset", good_s, 0);
    endtask

    task automatic test_random_loads();
        bq_t s;
        for (int k = 0; k < 6; k++) begin
            make_stream($urandom_range(1, 12), 1'($urandom_range(0, 1)), s);
            do_reset();
            run_stream($sformatf("rand%0d", k), s, $urandom_range(0, 2));
        end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
        good_s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        test_reset();
        test_good_load();
        test_post_done();
        test_bad_checksum();
        test_len_bounds();
        test_gaps();
        test_reset_mid_load();
        test_random_loads();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
